scrypt_romix_ctrl: RTL and testbench

SCRYPT_ROMIX_CTRL -- requirements
Module: scrypt_romix_ctrl

---
 rtl/scrypt_pkg.sv | 19 +
 rtl/scrypt_romix_ctrl.sv | 103 ++++++++++
 tb/tb_scrypt_romix_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scrypt_pkg.sv
// Shared scrypt definitions: block width, the ROMix controller state encoding,
// and the Integerify bit position.
package scrypt_pkg;

    localparam int BLOCK_W        = 1024;
    localparam int INTEGERIFY_LSB = 512;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        FILL_WAIT = 3'd2,
        MIX_RD    = 3'd3,
        MIX_XOR   = 3'd4,
        MIX_BM    = 3'd5,
        MIX_WAIT  = 3'd6,
        DONE      = 3'd7
    } romix_state_t;

endpackage

// File: rtl/scrypt_romix_ctrl.sv
// ROMix sequencer: fills the scratchpad with N successive BlockMix outputs, then
// performs N data-dependent read/xor/BlockMix rounds and reports the final block.
module scrypt_romix_ctrl
    import scrypt_pkg::*;
#(
    parameter int  N      = 1024,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] data_in,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] data_out,
    output logic               bm_enable,
    output logic [BLOCK_W-1:0] bm_data,
    input  logic [BLOCK_W-1:0] bm_hash,
    input  logic               bm_done,
    output logic               mem_we,
    output logic               mem_re,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata
);

    romix_state_t       state_reg;
    logic [ADDR_W-1:0]  i_reg;
    logic [BLOCK_W-1:0] x_reg;
    logic [BLOCK_W-1:0] data_out_reg;
    logic               i_last;

    assign i_last = (i_reg == ADDR_W'(N - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            x_reg        <= '0;
            data_out_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg     <= data_in;
                        i_reg     <= '0;
                        state_reg <= FILL;
                    end
                end
                FILL: state_reg <= FILL_WAIT;
                FILL_WAIT: begin
                    if (bm_done) begin
                        x_reg <= bm_hash;
                        if (i_last) begin
                            i_reg     <= '0;
                            state_reg <= MIX_RD;
                        end else begin
                            i_reg     <= i_reg + 1'b1;
                            state_reg <= FILL;
                        end
                    end
                end
                MIX_RD: state_reg <= MIX_XOR;
                // Read data returns exactly one cycle after mem_re, i.e. now.
                MIX_XOR: begin
                    x_reg     <= x_reg ^ mem_rdata;
                    state_reg <= MIX_BM;
                end
                MIX_BM: state_reg <= MIX_WAIT;
                MIX_WAIT: begin
                    if (bm_done) begin
                        x_reg <= bm_hash;
                        if (i_last) begin
                            // Load the result on entry so it is already valid while done pulses.
                            data_out_reg <= bm_hash;
                            state_reg    <= DONE;
                        end else begin
                            i_reg     <= i_reg + 1'b1;
                            state_reg <= MIX_RD;
                        end
                    end
                end
                DONE: begin
                    data_out_reg <= x_reg;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign bm_enable = (state_reg == FILL) || (state_reg == MIX_BM);
    assign mem_we    = (state_reg == FILL);
    assign mem_re    = (state_reg == MIX_RD);
    // Integerify: low address bits of word 16 pick the scratchpad entry.
    assign mem_addr  = (state_reg == MIX_RD) ? x_reg[INTEGERIFY_LSB +: ADDR_W] : i_reg;
    assign mem_wdata = x_reg;
    assign bm_data   = x_reg;
    assign data_out  = data_out_reg;

endmodule

// File: tb/tb_scrypt_romix_ctrl.sv
// Directed bench for scrypt_romix_ctrl with N=4 and a 3-cycle behavioural BlockMix
// (per-word +1) plus a 4-entry scratchpad with one-cycle registered read.
module tb_scrypt_romix_ctrl;

    localparam int N   = 4;
    localparam int L   = 3;
    localparam int LAT = 2 * N * L + 4 * N;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [1023:0] data_in = '0;
    logic          busy, done, bm_enable, mem_we, mem_re, bm_done;
    logic [1023:0] data_out, bm_data, bm_hash, mem_wdata, mem_rdata;
    logic [1:0]    mem_addr;

    int n_asserts = 0;
    int n_fail    = 0;

    scrypt_romix_ctrl #(.N(N)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out),
        .bm_enable(bm_enable), .bm_data(bm_data), .bm_hash(bm_hash), .bm_done(bm_done),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [1023:0] hmix(input logic [1023:0] x);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[32*k +: 32] = x[32*k +: 32] + 32'd1;
        return r;
    endfunction

    // BlockMix model: bm_done exactly L cycles after bm_enable; spur injects a bogus done.
    int            bm_cnt;
    logic [1023:0] bm_buf;
    logic          spur = 1'b0;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bm_cnt <= 0;
            bm_buf <= '0;
        end else if (bm_enable) begin
            bm_cnt <= L;
            bm_buf <= bm_data;
        end else if (bm_cnt > 0) begin
            bm_cnt <= bm_cnt - 1;
        end
    end
    assign bm_done = (bm_cnt == 1) || spur;
    assign bm_hash = spur ? {1024{1'b1}} : hmix(bm_buf);

    logic [1023:0] ram [0:N-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Passive monitor
    logic [1:0]    we_q[$];
    logic [1023:0] wd_q[$];
    logic [1:0]    re_q[$];
    int            done_cnt = 0;
    int            viol = 0;
    logic          waiting = 1'b0;
    logic [1023:0] hold;
    always @(negedge clk) begin
        if (!n_rst) begin
            waiting = 1'b0;
        end else begin
            if (mem_we) begin we_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
            if (mem_re) re_q.push_back(mem_addr);
            if (done) done_cnt++;
            if ((mem_we && mem_re) || (mem_re && bm_enable)) viol++;
            if (bm_enable) begin
                hold = bm_data;
                waiting = 1'b1;
            end else if (waiting) begin
                if (bm_data !== hold) viol++;
                if (bm_cnt == 1) waiting = 1'b0;
            end
        end
    end

    logic [1023:0] exp_v [0:N-1];
    logic [1:0]    exp_j [0:N-1];
    logic [1023:0] exp_out;

    task automatic compute_model(input logic [1023:0] din);
        logic [1023:0] x;
        logic [1:0]    j;
        x = din;
        for (int i = 0; i < N; i++) begin exp_v[i] = x; x = hmix(x); end
        for (int i = 0; i < N; i++) begin
            j = x[513:512];
            exp_j[i] = j;
            x = hmix(x ^ exp_v[j]);
        end
        exp_out = x;
    endtask

    function automatic logic [1023:0] counting_block(input int base);
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[32*k +: 32] = 32'(base + k);
        return r;
    endfunction

    // Runs one start; lat = edges from the sampling edge to the done cycle (-1 on timeout).
    task automatic run_block(input logic [1023:0] din, input int extra_start,
                             input bit spur_en, output int lat);
        bit spur_used;
        spur_used = 1'b0;
        lat = -1;
        we_q.delete(); wd_q.delete(); re_q.delete();
        @(negedge clk);
        data_in = din;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 200 && lat < 0; cyc++) begin
            @(posedge clk); #1;
            spur  = 1'b0;
            start = 1'b0;
            if (done) lat = cyc;
            if (cyc == extra_start) start = 1'b1;
            if (spur_en && !spur_used && mem_re) begin
                spur = 1'b1;
                spur_used = 1'b1;
            end
        end
        spur  = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_asserts++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_asserts++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_asserts++; if (bm_enable !== 1'b0) begin n_fail++; $display("FAIL reset_bm_enable got %b want 0", bm_enable); end
        n_asserts++; if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_asserts++; if (mem_re !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_re got %b want 0", mem_re); end
        n_asserts++; if (data_out !== '0)    begin n_fail++; $display("FAIL reset_data_out got %h want 0", data_out[63:0]); end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_run;
        int lat, d0, v0;
        d0 = done_cnt; v0 = viol;
        compute_model(counting_block(0));
        run_block(counting_block(0), 0, 1'b0, lat);
        $display("single run: latency %0d", lat);
        n_asserts++; if (lat !== LAT) begin n_fail++; $display("FAIL single_latency got %0d want %0d", lat, LAT); end
        n_asserts++; if (we_q.size() !== N) begin n_fail++; $display("FAIL fill_count got %0d want %0d", we_q.size(), N); end
        for (int i = 0; i < N && i < we_q.size(); i++) begin
            n_asserts++; if (we_q[i] !== 2'(i)) begin n_fail++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, we_q[i], i); end
            n_asserts++; if (wd_q[i] !== exp_v[i]) begin n_fail++; $display("FAIL fill_wdata[%0d] got %h want %h", i, wd_q[i][63:0], exp_v[i][63:0]); end
        end
        // Word 16 after the fill is 16+4=20, so the first Integerify index is 0.
        n_asserts++; if (re_q.size() > 0 && re_q[0] !== 2'd0) begin n_fail++; $display("FAIL first_j got %0d want 0", re_q[0]); end
        n_asserts++; if (re_q.size() !== N) begin n_fail++; $display("FAIL mix_count got %0d want %0d", re_q.size(), N); end
        for (int i = 0; i < N && i < re_q.size(); i++) begin
            n_asserts++; if (re_q[i] !== exp_j[i]) begin n_fail++; $display("FAIL mix_addr[%0d] got %0d want %0d", i, re_q[i], exp_j[i]); end
        end
        @(posedge clk); #1;
        n_asserts++; if (data_out !== exp_out) begin n_fail++; $display("FAIL single_result got %h want %h", data_out[63:0], exp_out[63:0]); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy); end
        n_asserts++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count got %0d want 1", done_cnt - d0); end
        n_asserts++; if (viol !== v0) begin n_fail++; $display("FAIL handshake_violations got %0d want 0", viol - v0); end
    endtask

    task automatic test_ignored_start;
        int lat, d0;
        d0 = done_cnt;
        compute_model(counting_block(100));
        run_block(counting_block(100), 10, 1'b0, lat);
        repeat (5) @(posedge clk);
        #1;
        $display("ignored start: latency %0d", lat);
        n_asserts++; if (lat !== LAT) begin n_fail++; $display("FAIL ignored_start_latency got %0d want %0d", lat, LAT); end
        n_asserts++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ignored_start_done_count got %0d want 1", done_cnt - d0); end
        n_asserts++; if (data_out !== exp_out) begin n_fail++; $display("FAIL ignored_start_result got %h want %h", data_out[63:0], exp_out[63:0]); end
        n_asserts++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_start_busy got %b want 0", busy); end
    endtask

    task automatic test_spurious_done;
        int lat;
        compute_model(counting_block(7));
        run_block(counting_block(7), 0, 1'b1, lat);
        @(posedge clk); #1;
        $display("spurious bm_done: latency %0d", lat);
        n_asserts++; if (lat !== LAT) begin n_fail++; $display("FAIL spurious_latency got %0d want %0d", lat, LAT); end
        n_asserts++; if (data_out !== exp_out) begin n_fail++; $display("FAIL spurious_result got %h want %h", data_out[63:0], exp_out[63:0]); end
    endtask

    task automatic test_reset_mid;
        int seen, d0, lat;
        bit reached;
        seen = 0; reached = 1'b0;
        @(negedge clk);
        data_in = counting_block(50);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
            @(posedge clk); #1;
            if (mem_re) begin
                seen++;
                if (seen == 2) reached = 1'b1;
            end
        end
        n_asserts++; if (!reached) begin n_fail++; $display("FAIL reset_mid_reach got 0 want 1"); end
        repeat (3) @(posedge clk);
        #1;
        n_asserts++; if (busy !== 1'b1 || bm_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mid_in_wait got busy=%b bm_enable=%b want 1/0", busy, bm_enable); end
        d0 = done_cnt;
        #2 n_rst = 1'b0;
        #1;
        n_asserts++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_busy got %b want 0", busy); end
        n_asserts++; if (done !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_done got %b want 0", done); end
        n_asserts++; if (bm_enable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bm_enable got %b want 0", bm_enable); end
        n_asserts++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin n_fail++; $display("FAIL mid_reset_mem got we=%b re=%b want 0/0", mem_we, mem_re); end
        n_asserts++; if (data_out !== '0)    begin n_fail++; $display("FAIL mid_reset_data_out got %h want 0", data_out[63:0]); end
        @(negedge clk); n_rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        n_asserts++; if (done_cnt !== d0) begin n_fail++; $display("FAIL mid_reset_no_done got %0d want 0", done_cnt - d0); end
        compute_model(counting_block(9));
        run_block(counting_block(9), 0, 1'b0, lat);
        @(posedge clk); #1;
        $display("after mid reset: latency %0d", lat);
        n_asserts++; if (lat !== LAT) begin n_fail++; $display("FAIL post_reset_latency got %0d want %0d", lat, LAT); end
        n_asserts++; if (data_out !== exp_out) begin n_fail++; $display("FAIL post_reset_result got %h want %h", data_out[63:0], exp_out[63:0]); end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [1023:0] first;
        compute_model(counting_block(1));
        first = exp_out;
        run_block(counting_block(1), 0, 1'b0, lat);
        // The next edge closes DONE; run_block then raises start in the first IDLE cycle.
        @(posedge clk); #1;
        n_asserts++; if (data_out !== first) begin n_fail++; $display("FAIL b2b_first_result got %h want %h", data_out[63:0], first[63:0]); end
        compute_model(counting_block(200));
        run_block(counting_block(200), 0, 1'b0, lat);
        @(posedge clk); #1;
        $display("back-to-back second run: latency %0d", lat);
        n_asserts++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        n_asserts++; if (data_out !== exp_out) begin n_fail++; $display("FAIL b2b_second_result got %h want %h", data_out[63:0], exp_out[63:0]); end
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_ignored_start();
        test_spurious_done();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
